// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU execution path: ALU opcodes,
// sequencer states, the HALT encoding and instruction field slicing.
// Instruction format: {op[1:0], rA[2:0], rB[2:0]}.
package exec_sequencer_pkg;

    localparam int unsigned INSTR_W = 8;

    // rB value that turns an OP_ONE encoding into HALT
    localparam logic [2:0] HALT_RB = 3'b111;

    typedef enum logic [1:0] {
        OP_ONE = 2'b00,   // a + 1
        OP_ADD = 2'b01,   // a + b
        OP_SUB = 2'b10,   // a - b
        OP_AND = 2'b11    // a & b
    } op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_RD_A,
        S_RD_B,
        S_ISSUE,
        S_EXEC_WAIT,
        S_WB,
        S_HALT
    } seq_state_e;

    function automatic op_e get_op(input logic [INSTR_W-1:0] instr);
        return op_e'(instr[7:6]);
    endfunction

    function automatic logic [2:0] get_ra(input logic [INSTR_W-1:0] instr);
        return instr[5:3];
    endfunction

    function automatic logic [2:0] get_rb(input logic [INSTR_W-1:0] instr);
        return instr[2:0];
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Bus bundle between the sequencer and its environment (instruction source,
// register file with one read port, ALU, status outputs).
//   master : sequencer side   slave : environment side
// Signals: instr_valid/instr/instr_ready, pc, rf_raddr/rf_rdata,
//          rf_we/rf_waddr/rf_wdata, alu_start/alu_op/alu_a/alu_b,
//          alu_done/alu_result, flag_zero, busy, halted, err.
interface exec_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
);
    logic              instr_valid;
    logic [7:0]        instr;
    logic              instr_ready;
    logic [PC_W-1:0]   pc;
    logic [2:0]        rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              alu_start;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;
    logic              flag_zero;
    logic              busy;
    logic              halted;
    logic              err;

    modport master (
        input  instr_valid, instr, rf_rdata, alu_done, alu_result,
        output instr_ready, pc, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_start, alu_op, alu_a, alu_b, flag_zero, busy, halted, err
    );

    modport slave (
        output instr_valid, instr, rf_rdata, alu_done, alu_result,
        input  instr_ready, pc, rf_raddr, rf_we, rf_waddr, rf_wdata,
               alu_start, alu_op, alu_a, alu_b, flag_zero, busy, halted, err
    );

endinterface

// File: rtl/exec_sequencer_alu_watchdog.sv
// ALU watchdog: counter loaded to 1 on entry to EXEC_WAIT, incremented each
// waiting cycle; expire_o is high once the count exceeds ALU_TIMEOUT.
// Ports: clk, rst_n (async active-low), load_i, inc_i, expire_o.
module alu_watchdog
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = (cnt_q > CNT_W'(ALU_TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// FETCH -> RD_A -> RD_B -> ISSUE -> EXEC_WAIT -> WB -> FETCH; HALT is terminal.
// Ports: clk, rst_n (async active-low), bus (exec_sequencer_if.master),
//        step_req (only when SEQ_SINGLE_STEP_EN is defined: FETCH accepts one
//        instruction per rising edge of step_req; otherwise FETCH free-runs).
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PC_W        = 8,
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic step_req,
`endif
    exec_sequencer_if.master bus
);
    seq_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        instr_q, instr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic              zero_q, zero_d, err_q, err_d;
    logic              fetch_en, accept;
    logic              wd_load, wd_inc, wd_expire;
    logic [DATA_W-1:0] issue_b;
    logic [2:0]        raddr;

`ifdef SEQ_SINGLE_STEP_EN
    // Rising edge of step_req arms one fetch; edges while armed are dropped.
    logic step_prev_q, armed_q, armed_d;

    always_comb begin
        armed_d = armed_q | (step_req & ~step_prev_q);
        if (accept) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            step_prev_q <= step_req;
            armed_q     <= armed_d;
        end
    end

    assign fetch_en = armed_q;
`else
    assign fetch_en = 1'b1;
`endif

    assign accept  = (state_q == S_FETCH) && fetch_en && bus.instr_valid;
    assign issue_b = (get_op(instr_q) == OP_ONE) ? DATA_W'(1) : bus.rf_rdata;

    alu_watchdog #(
        .ALU_TIMEOUT(ALU_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (wd_load),
        .inc_i    (wd_inc),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        raddr    = '0;
        wd_load  = 1'b0;
        wd_inc   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (accept) begin
                    instr_d = bus.instr;
                    if (get_op(bus.instr) == OP_ONE && get_rb(bus.instr) == HALT_RB) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                raddr   = get_ra(instr_q);
                state_d = S_RD_B;
            end
            S_RD_B: begin
                a_d     = bus.rf_rdata;
                raddr   = get_rb(instr_q);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                b_d     = issue_b;
                wd_load = 1'b1;
                state_d = S_EXEC_WAIT;
            end
            S_EXEC_WAIT: begin
                wd_inc = 1'b1;
                // A late done in the expiring cycle still wins over the timeout.
                if (bus.alu_done) begin
                    result_d = bus.alu_result;
                    state_d  = S_WB;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                zero_d  = (result_q == '0);
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    // Strobes decode straight from state so reset drops them immediately.
    assign bus.instr_ready = (state_q == S_FETCH) && fetch_en;
    assign bus.pc          = pc_q;
    assign bus.rf_raddr    = raddr;
    assign bus.rf_we       = (state_q == S_WB);
    assign bus.rf_waddr    = get_ra(instr_q);
    assign bus.rf_wdata    = result_q;
    assign bus.alu_start   = (state_q == S_ISSUE);
    assign bus.alu_op      = get_op(instr_q);
    assign bus.alu_a       = a_q;
    // B is only registered at the end of ISSUE, so present it directly there.
    assign bus.alu_b       = (state_q == S_ISSUE) ? issue_b : b_q;
    assign bus.flag_zero   = zero_q;
    assign bus.busy        = (state_q != S_FETCH) && (state_q != S_HALT);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.err         = err_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed + randomized bench for exec_sequencer. The environment (regfile with
// one-cycle read latency, ALU responder) lives here; expected values come from an
// instruction-level model: register array, pc counter and ALU arithmetic.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned PC_W        = 2;
    localparam int unsigned ALU_TIMEOUT = 15;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exec_sequencer_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    exec_sequencer #(
        .DATA_W      (DATA_W),
        .PC_W        (PC_W),
        .ALU_TIMEOUT (ALU_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment register file: preload port plus DUT write port, 1-cycle read.
    logic [7:0] mem [8];
    logic       pre_we;
    logic [2:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
        bus.rf_rdata <= mem[bus.rf_raddr];
    end

    // Reference model state
    logic [7:0]      ref_regs [8];
    logic [PC_W-1:0] ref_pc;
    logic            ref_zero;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        case (op)
            2'd0:    return a + 8'd1;
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return a & b;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        ref_pc   = '0;
        ref_zero = 1'b0;
    endtask

    // Called at a negedge with the DUT in FETCH; returns at the negedge after WB.
    task automatic run_instr(input logic [7:0] ins, input int delay, input bit stray);
        logic [1:0]      op;
        logic [2:0]      ra, rb;
        logic [7:0]      ea, eb, er;
        logic [PC_W-1:0] exp_pc;
        int              starts, busy_n, we_idx, start_idx;
        op = ins[7:6]; ra = ins[5:3]; rb = ins[2:0];
        ea = ref_regs[ra];
        eb = (op == 2'd0) ? 8'h01 : ref_regs[rb];
        er = alu_ref(op, ea, eb);
        starts = 0; busy_n = 0; we_idx = 0; start_idx = 0;
        chk("ready_in_fetch", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        for (int idx = 1; idx <= 40 && we_idx == 0; idx++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.alu_done    = 1'b0;
            if (stray && idx == 1) begin
                bus.alu_done   = 1'b1;
                bus.alu_result = ~er;
            end
            if (bus.busy) busy_n++;
            if (bus.alu_start) begin
                starts++;
                start_idx = idx;
                chk("alu_op", bus.alu_op, op);
                chk("alu_a", bus.alu_a, ea);
                chk("alu_b", bus.alu_b, eb);
            end
            if (start_idx != 0 && idx == start_idx + delay) begin
                bus.alu_done   = 1'b1;
                bus.alu_result = er;
            end
            if (bus.rf_we) begin
                we_idx = idx;
                chk("rf_waddr", bus.rf_waddr, ra);
                chk("rf_wdata", bus.rf_wdata, er);
                chk("held_alu_a", bus.alu_a, ea);
                chk("held_alu_b", bus.alu_b, eb);
                chk("zero_holds_in_wb", bus.flag_zero, ref_zero);
            end
        end
        chk("accept_to_we_latency", we_idx, 4 + delay);
        chk("alu_start_count", starts, 1);
        chk("busy_cycles", busy_n, 4 + delay);
        @(negedge clk);
        exp_pc = ref_pc + 1'b1;
        chk("we_one_cycle", bus.rf_we, 0);
        chk("pc_advance", bus.pc, exp_pc);
        chk("flag_zero", bus.flag_zero, (er == 8'h00));
        chk("back_to_fetch", bus.instr_ready, 1);
        ref_regs[ra] = er;
        ref_pc       = exp_pc;
        ref_zero     = (er == 8'h00);
    endtask

    logic [7:0] rnd_ins;
    int         start_idx;
    bit         any_we, any_start, any_ready, bad_pc, seen;
    logic       pre_halt, pre_err, post_halt, post_err;

    initial begin
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.alu_done    = 1'b0;
        bus.alu_result  = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        ref_pc = '0; ref_zero = 1'b0;

        for (int i = 0; i < 8; i++) ref_regs[i] = 8'($urandom);
        ref_regs[1] = 8'h05; ref_regs[2] = 8'h03; ref_regs[3] = 8'h77; ref_regs[4] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 3'(i); pre_data = ref_regs[i];
        end
        @(negedge clk);
        pre_we = 1'b0;
        rst_n  = 1'b1;

        // Reset state
        chk("rst_instr_ready", bus.instr_ready, 1);
        chk("rst_pc", bus.pc, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_alu_start", bus.alu_start, 0);
        chk("rst_flag_zero", bus.flag_zero, 0);

        // Directed: ADD r1,r2; SUB r3,r3; ONE r4 (FF+1 -> 0); AND r2,r1 with pc wrap 3->0
        run_instr(8'h4A, 1, 1'b0);
        run_instr(8'h9B, 1, 1'b1);
        run_instr(8'h20, 1, 1'b0);
        run_instr(8'hD1, 15, 1'b1);
        chk("pc_wrapped", bus.pc, 0);

        // Randomized instructions, ALU latency 1..15, stray done pulses
        for (int n = 0; n < 16; n++) begin
            rnd_ins = 8'($urandom);
            while (rnd_ins[7:6] == 2'b00 && rnd_ins[2:0] == 3'b111) rnd_ins = 8'($urandom);
            run_instr(rnd_ins, int'($urandom_range(1, 15)), 1'($urandom));
        end

        // ALU timeout: done withheld
        bus.instr = 8'h5A; bus.instr_valid = 1'b1;
        start_idx = 0; any_we = 1'b0;
        pre_halt = 1'bx; pre_err = 1'bx; post_halt = 1'bx; post_err = 1'bx;
        for (int idx = 1; idx <= 30; idx++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            if (bus.alu_start && start_idx == 0) start_idx = idx;
            if (bus.rf_we) any_we = 1'b1;
            if (start_idx != 0 && idx == start_idx + 16) begin
                pre_halt = bus.halted; pre_err = bus.err;
            end
            if (start_idx != 0 && idx == start_idx + 17) begin
                post_halt = bus.halted; post_err = bus.err;
            end
        end
        chk("to_start_idx", start_idx, 3);
        chk("to_halt_before", pre_halt, 0);
        chk("to_err_before", pre_err, 0);
        chk("to_halt_after", post_halt, 1);
        chk("to_err_after", post_err, 1);
        chk("to_no_writeback", any_we, 0);
        any_ready = 1'b0; any_start = 1'b0; bad_pc = 1'b0;
        bus.instr = 8'h4A; bus.instr_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.instr_ready) any_ready = 1'b1;
            if (bus.alu_start || bus.rf_we) any_start = 1'b1;
            if (bus.pc !== ref_pc) bad_pc = 1'b1;
        end
        bus.instr_valid = 1'b0;
        chk("to_halt_no_ready", any_ready, 0);
        chk("to_halt_no_activity", any_start, 0);
        chk("to_halt_pc_frozen", bad_pc, 0);
        chk("to_err_sticky", bus.err, 1);
        chk("to_busy_low", bus.busy, 0);

        do_reset();
        chk("rst2_err_clear", bus.err, 0);
        chk("rst2_halted_clear", bus.halted, 0);
        chk("rst2_pc", bus.pc, 0);

        // HALT instruction after one normal instruction
        run_instr(8'h11, 2, 1'b0);
        bus.instr = 8'h3F; bus.instr_valid = 1'b1;
        @(negedge clk);
        chk("halt_instr_halted", bus.halted, 1);
        chk("halt_instr_no_err", bus.err, 0);
        bus.instr = 8'h4A;
        any_ready = 1'b0; any_start = 1'b0; bad_pc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.instr_ready) any_ready = 1'b1;
            if (bus.alu_start || bus.rf_we) any_start = 1'b1;
            if (bus.pc !== ref_pc) bad_pc = 1'b1;
        end
        bus.instr_valid = 1'b0;
        chk("halt_no_ready", any_ready, 0);
        chk("halt_no_activity", any_start, 0);
        chk("halt_pc_frozen", bad_pc, 0);

        // Reset while alu_start is high
        do_reset();
        run_instr(8'h62, 1, 1'b0);
        bus.instr = 8'h4A; bus.instr_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            seen = bus.alu_start;
        end
        chk("issue_reached", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_issue_start_drop", bus.alu_start, 0);
        chk("rst_issue_pc", bus.pc, 0);
        @(negedge clk);
        rst_n = 1'b1; ref_pc = '0; ref_zero = 1'b0;

        // Reset in EXEC_WAIT with a done pending
        run_instr(8'h62, 1, 1'b0);
        bus.instr = 8'h4A; bus.instr_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            seen = bus.alu_start;
        end
        @(negedge clk);
        chk("exec_wait_busy", bus.busy, 1);
        bus.alu_done = 1'b1; bus.alu_result = 8'h5C;
        rst_n = 1'b0;
        #1;
        chk("rst_ew_pc", bus.pc, 0);
        chk("rst_ew_busy", bus.busy, 0);
        chk("rst_ew_we", bus.rf_we, 0);
        @(negedge clk);
        rst_n = 1'b1; ref_pc = '0; ref_zero = 1'b0;
        any_we = 1'b0; any_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.alu_done = 1'b0;
            if (bus.rf_we) any_we = 1'b1;
            if (bus.alu_start) any_start = 1'b1;
        end
        chk("abandon_no_we", any_we, 0);
        chk("abandon_no_start", any_start, 0);
        // Reads r1: the abandoned ADD must not have written it
        run_instr(8'h08, 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
